sdc_reg_sequencer: RTL and testbench

Hardware replacement for hand-scripted register pokes into sdc_controller: executes a stored program of register WRITE, WAIT and POLL-until-match steps on the controller's host register bus (addr/data_in/we/data_out). Used to bring up the card (clock divider, CMD0, CMD7, CMD17 and data-ISR clear) without a CPU. Generalises the host-side driver in bus widths and program depth, and adds status polling with timeout.

---
 rtl/sdc_reg_sequencer_pkg.sv | 44 ++++
 rtl/sdc_reg_sequencer.sv | 172 +++++++++++++++++
 tb/tb_sdc_reg_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdc_reg_sequencer_pkg.sv
// Shared opcode/state types and instruction helpers for the sdc_controller register sequencer.
// Instruction word, MSB first: op[1:0], addr[ADDR_W], arg1[DATA_W], arg0[DATA_W].
package sdc_seq_pkg;

    localparam int ADDR_W_DEF  = 7;
    localparam int DATA_W_DEF  = 8;
    localparam int INSTR_W_DEF = 2 + ADDR_W_DEF + 2 * DATA_W_DEF;

    localparam int ARG0_LSB_DEF = 0;
    localparam int ARG1_LSB_DEF = DATA_W_DEF;
    localparam int ADDR_LSB_DEF = 2 * DATA_W_DEF;
    localparam int OP_LSB_DEF   = 2 * DATA_W_DEF + ADDR_W_DEF;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_WAIT  = 2'd1,
        OP_POLL  = 2'd2,
        OP_END   = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_WAIT,
        ST_POLL_ADDR,
        ST_POLL_SAMPLE,
        ST_FINISH
    } state_e;

    // Builds a default-width instruction word for ROM images and benches.
    function automatic logic [INSTR_W_DEF-1:0] build_instr(
        input op_e                   op,
        input logic [ADDR_W_DEF-1:0] addr,
        input logic [DATA_W_DEF-1:0] arg1,
        input logic [DATA_W_DEF-1:0] arg0
    );
        return {op, addr, arg1, arg0};
    endfunction

endpackage

// File: rtl/sdc_reg_sequencer.sv
// Runs a stored WRITE/WAIT/POLL/END program on the sdc_controller host register bus.
// WRITE costs 5 cycles from fetch, a poll read 2 cycles; the controller bus has no backpressure.
module sdc_reg_sequencer
    import sdc_seq_pkg::*;
#(
    parameter  int ADDR_W    = 7,
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 32,
    parameter  int POLL_TO_W = 20,
    localparam int PC_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int INSTR_W   = 2 + ADDR_W + 2 * DATA_W
) (
    input  logic               clk,
    input  logic               rstn_async,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [PC_W-1:0]    err_pc,
    output logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [ADDR_W-1:0]  bus_addr,
    output logic [DATA_W-1:0]  bus_wdata,
    output logic               bus_we,
    input  logic [DATA_W-1:0]  bus_rdata
);

    localparam int ARG1_LSB = DATA_W;
    localparam int ADDR_LSB = 2 * DATA_W;
    localparam int OP_LSB   = 2 * DATA_W + ADDR_W;
    localparam int WAIT_W   = 2 * DATA_W;

    localparam logic [PC_W-1:0]      LAST_PC = PC_W'(DEPTH - 1);
    // One below all-ones: the failing read that would saturate the counter ends the poll.
    localparam logic [POLL_TO_W-1:0] TO_LAST = {{(POLL_TO_W-1){1'b1}}, 1'b0};

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [DATA_W-1:0]    mask_q, mask_d;
    logic [DATA_W-1:0]    match_q, match_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [POLL_TO_W-1:0] to_q, to_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 error_q, error_d;
    logic [PC_W-1:0]      err_pc_q, err_pc_d;
    logic                 advance;

    op_e                  dec_op;
    logic [ADDR_W-1:0]    dec_addr;
    logic [DATA_W-1:0]    dec_arg1;
    logic [DATA_W-1:0]    dec_arg0;

    assign dec_op   = op_e'(prog_data[OP_LSB +: 2]);
    assign dec_addr = prog_data[ADDR_LSB +: ADDR_W];
    assign dec_arg1 = prog_data[ARG1_LSB +: DATA_W];
    assign dec_arg0 = prog_data[0 +: DATA_W];

    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            mask_q   <= '0;
            match_q  <= '0;
            wait_q   <= '0;
            to_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            error_q  <= 1'b0;
            err_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            mask_q   <= mask_d;
            match_q  <= match_d;
            wait_q   <= wait_d;
            to_q     <= to_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            error_q  <= error_d;
            err_pc_q <= err_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        mask_d   = mask_q;
        match_d  = match_q;
        wait_d   = wait_q;
        to_d     = to_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        error_d  = error_q;
        err_pc_d = err_pc_q;
        advance  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    error_d = 1'b0;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                mask_d  = dec_arg1;
                match_d = dec_arg0;
                case (dec_op)
                    OP_WRITE: begin
                        state_d = ST_WR_SETUP;
                        addr_d  = dec_addr;
                        wdata_d = dec_arg0;
                    end
                    OP_WAIT: begin
                        state_d = ST_WAIT;
                        wait_d  = {dec_arg1, dec_arg0};
                    end
                    OP_POLL: begin
                        state_d = ST_POLL_ADDR;
                        addr_d  = dec_addr;
                        to_d    = '0;
                    end
                    default: state_d = ST_FINISH;
                endcase
            end
            ST_WR_SETUP:  state_d = ST_WR_STROBE;
            ST_WR_STROBE: state_d = ST_WR_HOLD;
            ST_WR_HOLD:   advance = 1'b1;
            ST_WAIT: begin
                // A count of N spends N cycles here; zero still costs one.
                if (wait_q <= WAIT_W'(1)) advance = 1'b1;
                else                      wait_d  = wait_q - WAIT_W'(1);
            end
            ST_POLL_ADDR: state_d = ST_POLL_SAMPLE;
            ST_POLL_SAMPLE: begin
                if ((bus_rdata & mask_q) == match_q) begin
                    advance = 1'b1;
                end else if (to_q == TO_LAST) begin
                    error_d  = 1'b1;
                    err_pc_d = pc_q;
                    state_d  = ST_FINISH;
                end else begin
                    to_d    = to_q + POLL_TO_W'(1);
                    state_d = ST_POLL_ADDR;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (pc_q == LAST_PC) begin
                state_d = ST_FINISH;
            end else begin
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_FETCH;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done      = (state_q == ST_FINISH) && !error_q;
    assign error     = error_q;
    assign err_pc    = err_pc_q;
    assign prog_addr = pc_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = (state_q == ST_WR_STROBE);

endmodule

// File: tb/tb_sdc_reg_sequencer.sv
// Scoreboard bench: a timeline model of each program predicts write strobes, done and timeout events.
module tb_sdc_reg_sequencer;
    import sdc_seq_pkg::*;

    localparam int DEPTH    = 4;
    localparam int TO_W     = 10;
    localparam int TO_MAX   = (1 << TO_W) - 1;
    localparam logic [6:0] POLL_REG = 7'h3C;

    typedef struct {
        int kind;   // 0 write strobe, 1 done, 2 timeout
        int t;
        int a;
        int d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rstn_async = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error, bus_we;
    logic [1:0]  err_pc, prog_addr;
    logic [24:0] prog_data = '0;
    logic [6:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = '0;

    logic [24:0] prog_mem [DEPTH];
    ev_t         exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          raise_at = 0;
    logic [7:0]  pat = '0;
    logic [7:0]  status_val;
    bit          sb_en = 1'b0;
    bit          run_end = 1'b0;
    bit          post_chk = 1'b0;
    logic [6:0]  prev_addr = '0;
    logic [7:0]  prev_wdata = '0;
    logic [6:0]  we_addr;
    logic [7:0]  we_wdata;
    logic        prev_err = 1'b0;
    ev_t         mon_e;
    int          rel;

    sdc_reg_sequencer #(
        .ADDR_W(7), .DATA_W(8), .DEPTH(DEPTH), .POLL_TO_W(TO_W)
    ) dut (
        .clk(clk), .rstn_async(rstn_async), .start(start), .busy(busy), .done(done),
        .error(error), .err_pc(err_pc), .prog_addr(prog_addr), .prog_data(prog_data),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM and a controller whose status register reads back one cycle late.
    assign status_val = ((cyc - t0) >= raise_at) ? pat : 8'h00;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prog_data <= prog_mem[prog_addr];
        bus_rdata <= (bus_addr == POLL_REG) ? status_val : 8'h00;
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic push(input int k, input int t, input int a, input int d);
        ev_t e;
        e.kind = k; e.t = t; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    // Timeline model: t is the cycle offset of each instruction's fetch from the first fetch.
    task automatic model();
        int t, k, n, v;
        bit fin;
        logic [1:0] op;
        logic [6:0] a;
        logic [7:0] a1, a0;
        t = 0;
        for (int pc = 0; pc < DEPTH; pc++) begin
            {op, a, a1, a0} = prog_mem[pc];
            if (op == 2'd0) begin
                push(0, t + 3, a, a0);
                t += 5;
            end else if (op == 2'd1) begin
                n = {a1, a0};
                t += 2 + ((n == 0) ? 1 : n);
            end else if (op == 2'd2) begin
                k = 0;
                fin = 0;
                while (!fin) begin
                    // read k presents its address at t+2+2k; data arrives the next cycle
                    v = (a == POLL_REG && (t + 2 + 2 * k) >= raise_at) ? int'(pat) : 0;
                    if ((v & int'(a1)) == int'(a0)) begin
                        t += 2 + 2 * (k + 1);
                        fin = 1;
                    end else if (k + 1 == TO_MAX) begin
                        push(2, t + 2 + 2 * (k + 1), pc, 0);
                        return;
                    end else begin
                        k++;
                    end
                end
            end else begin
                push(1, t + 2, 0, 0);
                return;
            end
        end
        push(1, t, 0, 0);
    endtask

    always @(negedge clk) begin
        rel = cyc - t0;
        if (sb_en && rstn_async) begin
            if (post_chk) begin
                chk("we_post_addr", int'(bus_addr), int'(we_addr));
                chk("we_post_wdata", int'(bus_wdata), int'(we_wdata));
                post_chk = 1'b0;
            end
            if (bus_we) begin
                chk("we_pre_addr", int'(prev_addr), int'(bus_addr));
                chk("we_pre_wdata", int'(prev_wdata), int'(bus_wdata));
                we_addr  = bus_addr;
                we_wdata = bus_wdata;
                post_chk = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("we_kind", 0, mon_e.kind);
                    chk("we_cycle", rel, mon_e.t);
                    chk("we_addr", int'(bus_addr), mon_e.a);
                    chk("we_wdata", int'(bus_wdata), mon_e.d);
                end
            end
            if (done) begin
                chk("done_busy", int'(busy), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_kind", 1, mon_e.kind);
                    chk("done_cycle", rel, mon_e.t);
                end
                run_end = 1'b1;
            end
            if (error && !prev_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_error", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("err_kind", 2, mon_e.kind);
                    chk("err_cycle", rel, mon_e.t);
                    chk("err_pc", int'(err_pc), mon_e.a);
                end
                chk("err_busy", int'(busy), 0);
                run_end = 1'b1;
            end
        end
        prev_addr  = bus_addr;
        prev_wdata = bus_wdata;
        prev_err   = error;
    end

    task automatic run_prog(input int raise, input logic [7:0] pt, input bit poke);
        int poke_at;
        exp_q.delete();
        raise_at = raise;
        pat      = pt;
        model();
        run_end  = 1'b0;
        post_chk = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t0 = cyc;
        chk("busy_after_start", int'(busy), 1);
        chk("error_cleared", int'(error), 0);
        poke_at = $urandom_range(1, 12);
        for (int i = 0; i < 6000 && !run_end; i++) begin
            @(negedge clk);
            if (poke && i == poke_at && busy) begin
                start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
        end
        if (!run_end) chk("run_timeout", 0, 1);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_busy", int'(busy), 0);
        exp_q.delete();
    endtask

    function automatic logic [24:0] rand_instr(input logic [7:0] pt);
        int r;
        logic [7:0] m;
        r = $urandom_range(0, 99);
        m = 8'($urandom_range(1, 255));
        if (r < 40)      return build_instr(OP_WRITE, 7'($urandom), 8'($urandom), 8'($urandom));
        else if (r < 60) return build_instr(OP_WAIT, 7'($urandom), 8'h00, 8'($urandom_range(0, 30)));
        else if (r < 85) return build_instr(OP_POLL, POLL_REG, m, pt & m);
        else             return build_instr(OP_END, 7'h00, 8'h00, 8'h00);
    endfunction

    initial begin
        logic [7:0] rp;
        for (int i = 0; i < DEPTH; i++) prog_mem[i] = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_err_pc", int'(err_pc), 0);
        chk("rst_prog_addr", int'(prog_addr), 0);
        chk("rst_bus_addr", int'(bus_addr), 0);
        chk("rst_bus_wdata", int'(bus_wdata), 0);
        chk("rst_bus_we", int'(bus_we), 0);
        @(negedge clk) rstn_async = 1'b1;
        sb_en = 1'b1;

        // bring-up writes
        prog_mem[0] = build_instr(OP_WRITE, 7'h24, 8'h00, 8'h02);
        prog_mem[1] = build_instr(OP_WRITE, 7'h05, 8'h00, 8'h00);
        prog_mem[2] = build_instr(OP_WRITE, 7'h00, 8'h00, 8'h00);
        prog_mem[3] = build_instr(OP_END, 7'h00, 8'h00, 8'h00);
        run_prog(0, 8'h00, 1'b1);

        // long and zero waits between writes
        prog_mem[0] = build_instr(OP_WRITE, 7'h01, 8'h00, 8'h11);
        prog_mem[1] = build_instr(OP_WAIT, 7'h00, 8'h03, 8'hE8);
        prog_mem[2] = build_instr(OP_WRITE, 7'h02, 8'h00, 8'h22);
        run_prog(0, 8'h00, 1'b0);
        prog_mem[1] = build_instr(OP_WAIT, 7'h00, 8'h00, 8'h00);
        run_prog(0, 8'h00, 1'b0);

        // poll for data ISR bit0 raised after 500 cycles
        prog_mem[0] = build_instr(OP_POLL, POLL_REG, 8'h01, 8'h01);
        prog_mem[1] = build_instr(OP_WRITE, 7'h11, 8'h00, 8'h5A);
        prog_mem[2] = build_instr(OP_END, 7'h00, 8'h00, 8'h00);
        run_prog(500, 8'h01, 1'b0);
        chk("poll_no_error", int'(error), 0);

        // poll that never matches times out at PC 1
        prog_mem[0] = build_instr(OP_WRITE, 7'h10, 8'h00, 8'hAA);
        prog_mem[1] = build_instr(OP_POLL, POLL_REG, 8'h01, 8'h01);
        prog_mem[2] = build_instr(OP_WRITE, 7'h12, 8'h00, 8'h33);
        prog_mem[3] = build_instr(OP_END, 7'h00, 8'h00, 8'h00);
        run_prog(32'h3FFF_FFFF, 8'h00, 1'b0);
        chk("timeout_sticky", int'(error), 1);

        // no END: runs off the end of the program
        for (int i = 0; i < DEPTH; i++)
            prog_mem[i] = build_instr(OP_WRITE, 7'(8'h40 + i), 8'h00, 8'(8'hC0 + i));
        run_prog(0, 8'h00, 1'b1);

        for (int r = 0; r < 25; r++) begin
            rp = 8'($urandom);
            for (int i = 0; i < DEPTH; i++) prog_mem[i] = rand_instr(rp);
            run_prog($urandom_range(0, 60), rp, ($urandom_range(0, 1) == 1));
        end

        // reset in the middle of a write strobe, then a clean rerun
        sb_en = 1'b0;
        prog_mem[0] = build_instr(OP_WRITE, 7'h24, 8'h00, 8'h02);
        prog_mem[1] = build_instr(OP_WRITE, 7'h05, 8'h00, 8'h00);
        prog_mem[2] = build_instr(OP_WRITE, 7'h00, 8'h00, 8'h00);
        prog_mem[3] = build_instr(OP_END, 7'h00, 8'h00, 8'h00);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 20 && !bus_we; i++) @(negedge clk);
        chk("saw_strobe", int'(bus_we), 1);
        rstn_async = 1'b0;
        #1;
        chk("rst_mid_we", int'(bus_we), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_pc", int'(prog_addr), 0);
        @(negedge clk) rstn_async = 1'b1;
        sb_en = 1'b1;
        run_prog(0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
